// File: rtl/watch_mode_ctrl_pkg.sv
// Shared encodings for the watch mode controller: mode values and front-panel button bit positions.
package watch_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_WATCH = 2'd0,
    MODE_SW    = 2'd1,
    MODE_TMR   = 2'd2,
    MODE_ALARM = 2'd3
  } mode_t;

  localparam int BTN_START = 0;
  localparam int BTN_HOUR  = 1;
  localparam int BTN_MIN   = 2;
  localparam int BTN_CLEAR = 3;
  localparam int BTN_W     = 4;

  // Mode button rotation; ALARM is never reached this way.
  function automatic mode_t next_mode_cycle(input mode_t cur);
    mode_t res;
    case (cur)
      MODE_WATCH: res = MODE_SW;
      MODE_SW:    res = MODE_TMR;
      default:    res = MODE_WATCH;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Free-running 1 s divider: sec_tick on the wrap cycle, half_tick mid-second.
// One-cycle pulses decoded from the counter; no backpressure.
module sec_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic sec_tick,
  output logic half_tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_HZ / 2 - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sec_tick  = (cnt == CNT_LAST);
  assign half_tick = (cnt == CNT_HALF);

endmodule

// File: rtl/watch_mode_ctrl.sv
// Mode FSM sharing buttons and display between watch, stopwatch and timer; alarm preempts, idle falls back to WATCH.
// All outputs registered, one-cycle latency; pulses are never stalled, dropped ones are simply lost.
module watch_mode_ctrl
  import watch_mode_ctrl_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int IDLE_SEC  = 30,
  parameter int ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       mode_pedge,
  input  logic [3:0] btn_pedge,
  input  logic       timer_done,
  input  logic [7:0] watch_hour,
  input  logic [7:0] watch_min,
  input  logic [7:0] sw_sec,
  input  logic [7:0] sw_csec,
  input  logic [7:0] tmr_min,
  input  logic [7:0] tmr_sec,
  output logic [3:0] watch_btn,
  output logic [3:0] sw_btn,
  output logic [3:0] tmr_btn,
  output logic [1:0] mode,
  output logic [7:0] disp_hi,
  output logic [7:0] disp_lo,
  output logic       alarm,
  output logic       colon
);

  localparam int IW = $clog2(IDLE_SEC + 1);
  localparam int AW = $clog2(ALARM_SEC + 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_SEC - 1);
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);

  mode_t         state;
  mode_t         nxt;
  logic [IW-1:0] idle_cnt;
  logic [AW-1:0] alarm_cnt;
  logic          sec_tick;
  logic          half_tick;
  logic          any_evt;
  logic          in_busy;
  logic          idle_expire;
  logic          alarm_expire;
  logic          fwd;

  sec_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk      (clk),
    .rst      (reset_p),
    .sec_tick (sec_tick),
    .half_tick(half_tick)
  );

  always_comb begin
    any_evt      = mode_pedge | (|btn_pedge);
    in_busy      = (state == MODE_SW) || (state == MODE_TMR);
    idle_expire  = in_busy && sec_tick && (idle_cnt == IDLE_LAST);
    alarm_expire = (state == MODE_ALARM) && sec_tick && (alarm_cnt == ALARM_LAST);
    // Buttons coinciding with a mode change or expiry are swallowed.
    fwd          = !mode_pedge && !timer_done && (state != MODE_ALARM);

    nxt = state;
    if (timer_done) begin
      nxt = MODE_ALARM;
    end else if (state == MODE_ALARM) begin
      if (any_evt || alarm_expire) begin
        nxt = MODE_TMR;
      end
    end else if (idle_expire) begin
      nxt = MODE_WATCH;
    end else if (mode_pedge) begin
      nxt = next_mode_cycle(state);
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state <= MODE_WATCH;
      alarm <= 1'b0;
    end else begin
      state <= nxt;
      alarm <= (nxt == MODE_ALARM);
    end
  end

  assign mode = state;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      watch_btn <= '0;
      sw_btn    <= '0;
      tmr_btn   <= '0;
    end else begin
      watch_btn <= (fwd && state == MODE_WATCH) ? btn_pedge : 4'd0;
      sw_btn    <= (fwd && state == MODE_SW)    ? btn_pedge : 4'd0;
      tmr_btn   <= (fwd && state == MODE_TMR)   ? btn_pedge : 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      idle_cnt <= '0;
    end else if ((nxt != state) || any_evt || !in_busy) begin
      idle_cnt <= '0;
    end else if (sec_tick) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // A fresh expiry while already alarming restarts the alarm duration.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      alarm_cnt <= '0;
    end else if (timer_done || (state != MODE_ALARM)) begin
      alarm_cnt <= '0;
    end else if (sec_tick) begin
      alarm_cnt <= alarm_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      disp_hi <= '0;
      disp_lo <= '0;
    end else begin
      case (state)
        MODE_WATCH: begin
          disp_hi <= watch_hour;
          disp_lo <= watch_min;
        end
        MODE_SW: begin
          disp_hi <= sw_sec;
          disp_lo <= sw_csec;
        end
        default: begin
          disp_hi <= tmr_min;
          disp_lo <= tmr_sec;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      colon <= 1'b0;
    end else begin
      case (nxt)
        MODE_WATCH: begin
          if (sec_tick) begin
            colon <= 1'b1;
          end else if (half_tick) begin
            colon <= 1'b0;
          end
        end
        MODE_ALARM: begin
          if (sec_tick || half_tick) begin
            colon <= ~colon;
          end
        end
        default: colon <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Bench for watch_mode_ctrl: directed scenarios plus randomized pulses checked every cycle against a reference model.
module tb_watch_mode_ctrl;
  import watch_mode_ctrl_pkg::*;

  localparam int CLK_HZ    = 10;
  localparam int IDLE_SEC  = 3;
  localparam int ALARM_SEC = 2;

  logic       clk = 1'b0;
  logic       reset_p;
  logic       mode_pedge;
  logic [3:0] btn_pedge;
  logic       timer_done;
  logic [7:0] watch_hour, watch_min, sw_sec, sw_csec, tmr_min, tmr_sec;
  logic [3:0] watch_btn, sw_btn, tmr_btn;
  logic [1:0] mode;
  logic [7:0] disp_hi, disp_lo;
  logic       alarm, colon;

  always #5 clk = ~clk;

  watch_mode_ctrl #(
    .CLK_HZ(CLK_HZ), .IDLE_SEC(IDLE_SEC), .ALARM_SEC(ALARM_SEC)
  ) dut (
    .clk(clk), .reset_p(reset_p), .mode_pedge(mode_pedge), .btn_pedge(btn_pedge),
    .timer_done(timer_done), .watch_hour(watch_hour), .watch_min(watch_min),
    .sw_sec(sw_sec), .sw_csec(sw_csec), .tmr_min(tmr_min), .tmr_sec(tmr_sec),
    .watch_btn(watch_btn), .sw_btn(sw_btn), .tmr_btn(tmr_btn), .mode(mode),
    .disp_hi(disp_hi), .disp_lo(disp_lo), .alarm(alarm), .colon(colon)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode as an integer, seconds elapsed since the last activity / alarm start.
  int         m_mode, m_idle, m_asec, cyc;
  logic       m_colon;
  logic [3:0] e_wbtn, e_sbtn, e_tbtn;
  logic [7:0] e_hi, e_lo;

  task automatic model_reset();
    m_mode = 0; m_idle = 0; m_asec = 0; cyc = 0; m_colon = 1'b0;
    e_wbtn = '0; e_sbtn = '0; e_tbtn = '0; e_hi = '0; e_lo = '0;
  endtask

  task automatic model_step();
    int  phase, prev, nxt;
    bit  sec, half, any;
    phase = cyc % CLK_HZ;
    cyc++;
    sec  = (phase == CLK_HZ - 1);
    half = (phase == CLK_HZ / 2 - 1);
    prev = m_mode;
    case (prev)
      0: begin e_hi = watch_hour; e_lo = watch_min; end
      1: begin e_hi = sw_sec;     e_lo = sw_csec;   end
      default: begin e_hi = tmr_min; e_lo = tmr_sec; end
    endcase
    e_wbtn = '0; e_sbtn = '0; e_tbtn = '0;
    if (!timer_done && !mode_pedge) begin
      if (prev == 0) e_wbtn = btn_pedge;
      if (prev == 1) e_sbtn = btn_pedge;
      if (prev == 2) e_tbtn = btn_pedge;
    end
    any = mode_pedge || (btn_pedge != 4'd0);
    nxt = prev;
    if (timer_done) begin
      nxt = 3;
      m_asec = 0;
    end else if (prev == 3) begin
      if (sec) m_asec++;
      if (any || m_asec >= ALARM_SEC) nxt = 2;
    end else if ((prev == 1 || prev == 2) && sec && (m_idle + 1 >= IDLE_SEC)) begin
      nxt = 0;
    end else if (mode_pedge) begin
      nxt = (prev + 1) % 3;
    end
    if (nxt != prev || any || !(nxt == 1 || nxt == 2)) m_idle = 0;
    else if (sec) m_idle++;
    if (nxt == 0) begin
      if (sec) m_colon = 1'b1;
      else if (half) m_colon = 1'b0;
    end else if (nxt == 3) begin
      if (sec || half) m_colon = ~m_colon;
    end else begin
      m_colon = 1'b1;
    end
    m_mode = nxt;
  endtask

  task automatic compare_all();
    check_eq("mode", mode, m_mode);
    check_eq("alarm", alarm, (m_mode == 3));
    check_eq("colon", colon, m_colon);
    check_eq("watch_btn", watch_btn, e_wbtn);
    check_eq("sw_btn", sw_btn, e_sbtn);
    check_eq("tmr_btn", tmr_btn, e_tbtn);
    check_eq("disp_hi", disp_hi, e_hi);
    check_eq("disp_lo", disp_lo, e_lo);
  endtask

  // Inputs set before the call are sampled on the next edge, then pulses are cleared.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    mode_pedge = 1'b0;
    btn_pedge  = 4'd0;
    timer_done = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pm, pb, pt;
    reset_p = 1'b1; mode_pedge = 1'b0; btn_pedge = 4'd0; timer_done = 1'b0;
    watch_hour = 8'd9; watch_min = 8'd41; sw_sec = 8'd0; sw_csec = 8'd0;
    tmr_min = 8'd5; tmr_sec = 8'd17;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_p = 1'b0;

    check_eq("rst_mode", mode, 0);
    check_eq("rst_btns", {watch_btn, sw_btn, tmr_btn}, 0);
    check_eq("rst_disp", {disp_hi, disp_lo}, 0);
    check_eq("rst_alarm", alarm, 0);
    check_eq("rst_colon", colon, 0);

    // Button routing in WATCH
    btn_pedge = 4'b0010;
    step();
    check_eq("t1_wbtn", watch_btn, 4'b0010);
    check_eq("t1_others", {sw_btn, tmr_btn}, 0);
    check_eq("t1_mode", mode, 0);
    step();
    check_eq("t1_wbtn_one_cycle", watch_btn, 0);

    // Mode rotation and stopwatch display
    sw_sec = 8'd12; sw_csec = 8'd34;
    mode_pedge = 1'b1; step();
    check_eq("t2_mode1", mode, 1);
    step();
    check_eq("t2_disp", {disp_hi, disp_lo}, {8'd12, 8'd34});
    mode_pedge = 1'b1; step();
    check_eq("t2_mode2", mode, 2);
    mode_pedge = 1'b1; step();
    check_eq("t2_mode0", mode, 0);

    // Button coinciding with mode change is dropped
    mode_pedge = 1'b1; btn_pedge = 4'b0001; step();
    check_eq("t3_mode", mode, 1);
    check_eq("t3_no_btn", {watch_btn, sw_btn, tmr_btn}, 0);

    // Alarm entry, button exit, and self-clear
    mode_pedge = 1'b1; step();
    check_eq("t4_tmr", mode, 2);
    timer_done = 1'b1; step();
    check_eq("t4_alarm_mode", mode, 3);
    check_eq("t4_alarm_on", alarm, 1);
    btn_pedge = 4'b1000; step();
    check_eq("t4_exit_mode", mode, 2);
    check_eq("t4_exit_alarm", alarm, 0);
    check_eq("t4_exit_consumed", tmr_btn, 0);
    timer_done = 1'b1; step();
    check_eq("t4_realarm", mode, 3);
    n = 0;
    while (mode == 2'd3 && n < 20) begin step(); n++; end
    check_eq("t4_selfclear_mode", mode, 2);
    check_eq("t4_selfclear_alarm", alarm, 0);

    // Idle timeout from STOPWATCH, then restart by a button
    mode_pedge = 1'b1; step();
    mode_pedge = 1'b1; step();
    check_eq("t5_sw", mode, 1);
    n = 0;
    while (mode == 2'd1 && n < 30) begin step(); n++; end
    check_eq("t5_timeout_mode", mode, 0);
    check_eq("t5_timeout_not_early", (n >= (IDLE_SEC - 1) * CLK_HZ + 1), 1);
    mode_pedge = 1'b1; step();
    repeat (14) step();
    btn_pedge = 4'b0100; step();
    check_eq("t5_btn_fwd", sw_btn, 4'b0100);
    check_eq("t5_still_sw", mode, 1);
    n = 0;
    while (mode == 2'd1 && n < 40) begin step(); n++; end
    check_eq("t5_restart_mode", mode, 0);
    check_eq("t5_restart_range", (n >= (IDLE_SEC - 1) * CLK_HZ + 1) && (n <= IDLE_SEC * CLK_HZ), 1);

    // Asynchronous reset in ALARM
    timer_done = 1'b1; step();
    check_eq("t6_alarm", mode, 3);
    #2;
    reset_p = 1'b1;
    #1;
    check_eq("t6_async_mode", mode, 0);
    check_eq("t6_async_alarm", alarm, 0);
    @(posedge clk);
    @(negedge clk);
    reset_p = 1'b0;
    model_reset();

    // Randomized phase: blocks alternate busy and quiet traffic
    for (int blk = 0; blk < 30; blk++) begin
      if (blk % 3 == 0) begin pm = 60; pb = 80; pt = 150; end
      else begin pm = 10; pb = 5; pt = 40; end
      for (int i = 0; i < 80; i++) begin
        watch_hour = 8'($urandom); watch_min = 8'($urandom);
        sw_sec = 8'($urandom); sw_csec = 8'($urandom);
        tmr_min = 8'($urandom); tmr_sec = 8'($urandom);
        mode_pedge = ($urandom_range(0, pm - 1) == 0);
        if ($urandom_range(0, pb - 1) == 0)
          btn_pedge = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
        timer_done = ($urandom_range(0, pt - 1) == 0);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/watch_mode_ctrl.md
# watch_mode_ctrl

Mode controller for the multi-function watch. It shares one set of four front-panel buttons and one 4-digit display between the watch, stopwatch and countdown-timer blocks. It cycles the active mode on a mode button, routes button pulses only to the active function, and muxes that function's time fields to the display. It also preempts everything with an alarm state when the timer expires, and falls back to watch mode after an idle timeout.

## Interface
- CLK_HZ, 100_000_000, system clock frequency; the 1 s tick period in cycles.
- IDLE_SEC, 30, seconds without any button in STOPWATCH/TIMER before returning to WATCH.
- ALARM_SEC, 10, seconds the alarm sounds before self-clearing.
- clk  in  1  system clock, rising edge.
- reset_p  in  1  reset, asynchronous, active-high.
- mode_pedge  in  1  one-cycle pulse from upstream button_cntr; advances mode.
- btn_pedge  in  4  one-cycle function-button pulses. Bit 0 is start_pause, bit 1 hour_up, bit 2 min_up, bit 3 clear.
- timer_done  in  1  one-cycle pulse from the countdown timer at expiry.
- watch_hour, watch_min  in  8 each  watch fields, binary.
- sw_sec, sw_csec  in  8 each  stopwatch seconds and centiseconds.
- tmr_min, tmr_sec  in  8 each  timer remaining time.
- watch_btn, sw_btn, tmr_btn  out  4 each  routed button pulses, one per function.
- mode  out  2  0 WATCH, 1 STOPWATCH, 2 TIMER, 3 ALARM.
- disp_hi, disp_lo  out  8 each  left and right display fields, binary (BCD conversion is downstream).
- alarm  out  1  buzzer enable.
- colon  out  1  display colon.

## Operation
- FSM states WATCH, STOPWATCH, TIMER, ALARM.
  - mode_pedge moves WATCH→STOPWATCH→TIMER→WATCH.
  - timer_done from any state enters ALARM.
- Priority within one cycle, highest first: timer_done, then ALARM exit, then idle timeout, then mode_pedge, then btn_pedge.
  - A btn_pedge in the same cycle as mode_pedge or timer_done is dropped, not forwarded.
- Routing:
  - btn_pedge is forwarded to the function selected by the state at the input cycle. The matching output bit pulses for exactly one cycle.
  - The other two button outputs stay 0.
  - In ALARM nothing is forwarded.
- ALARM:
  - alarm=1 while in this state.
  - Any mode_pedge or btn_pedge, or ALARM_SEC seconds elapsing, exits to TIMER with alarm=0. The exiting pulse is consumed.
  - timer_done while already in ALARM restarts the alarm second count.
- Seconds tick: a free-running counter 0..CLK_HZ-1 produces sec_tick on the cycle it wraps, and half_tick at CLK_HZ/2-1.
- Idle timeout:
  - The idle counter clears on entry to any state and on any mode_pedge or btn_pedge. It increments on sec_tick in STOPWATCH or TIMER.
  - When it reaches IDLE_SEC the FSM goes to WATCH.
  - The idle counter is inactive in WATCH and ALARM.
- Display mux:
  - WATCH shows hour, min.
  - STOPWATCH shows sec, csec.
  - TIMER and ALARM show tmr_min, tmr_sec.
- colon:
  - In WATCH it is 1 for the first half of each second (set on sec_tick, cleared on half_tick).
  - In ALARM it toggles every half_tick and sec_tick.
  - Otherwise it is constant 1.
- Function blocks keep running in the background; this block never resets them.

## Timing
- Reset: mode=0 (WATCH), all *_btn=0, disp_hi=disp_lo=0, alarm=0, colon=0. Tick, idle and alarm counters are 0.
- State update: one cycle. mode reflects a pulse on the next rising edge.
- Routed button pulse: one-cycle latency, registered.
- Display: registered, one-cycle latency from field change or mode change.
- The idle and alarm timeouts count whole sec_ticks. Actual elapsed time is between N-1 and N seconds after the last event.
- Reset mid-ALARM clears alarm immediately, asynchronously.

## Structure
- A shared package holds:
  - the mode encodings (MODE_WATCH=2'd0, MODE_SW=2'd1, MODE_TMR=2'd2, MODE_ALARM=2'd3);
  - the button bit indices (BTN_START=0, BTN_HOUR=1, BTN_MIN=2, BTN_CLEAR=3).
- One sub-module, sec_tick_gen, takes parameter CLK_HZ and outputs sec_tick and half_tick. It is reusable by watch/stopwatch.
- FSM, routing, idle/alarm counters and display mux stay in watch_mode_ctrl.

## Test plan
Bench uses CLK_HZ=10, IDLE_SEC=3, ALARM_SEC=2.
1. Reset, then btn_pedge=4'b0010 → watch_btn=4'b0010 for one cycle the next cycle; sw_btn=tmr_btn=0; mode=0.
2. Three mode_pedge pulses → mode 1, 2, 0. With sw_sec=12, sw_csec=34, disp shows 12/34 one cycle after mode=1.
3. mode_pedge and btn_pedge[0] in the same cycle from WATCH → mode=1; no pulse on any *_btn output.
4. In TIMER, pulse timer_done → mode=3, alarm=1. Then btn_pedge[3] → mode=2, alarm=0, tmr_btn stays 0. Repeat without a button → alarm clears within 20 cycles of entry.
5. Enter STOPWATCH, no buttons → mode returns to 0 within 30 cycles. Repeat with a btn_pedge at cycle 15 → the timeout restarts from that pulse.
6. Assert reset_p mid-ALARM → alarm and mode drop to 0 asynchronously, before the next clock edge.
